sensor_event_tx: RTL and testbench
==================================

// Module: sensor_event_tx
// PURPOSE
//  Front end that drives the scoreboard FSM's sensor inputs. Takes raw 3-bit zone
//  sensors {S1,S2,S3} from two bots, synchronises and debounces them, and emits one
//  event per stable change on a valid/ready channel per bot (Sensors_reg1/2 side).
//  Raises map_req when both bots report ZONE_GOAL (3'b111) in the same cycle.
// PARAMETERS
//  DEBOUNCE_CYCLES  10  cycles a synced code must hold before it is accepted (>=2)
//  CNT_W            4   debounce counter width, >= clog2(DEBOUNCE_CYCLES+1)
// PORTS
//  clk          in   1  system clock, all logic on rising edge
//  rst          in   1  asynchronous, active-low reset
//  sens1_raw    in   3  bot 1 raw sensors {S1,S2,S3}, asynchronous to clk
//  sens2_raw    in   3  bot 2 raw sensors, asynchronous to clk
//  sens1_code   out  3  bot 1 accepted zone code (Sensors_reg1 to scoreboard)
//  sens1_valid  out  1  bot 1 event pending
//  sens1_ready  in   1  scoreboard accepts bot 1 event
//  sens2_code   out  3  bot 2 accepted zone code (Sensors_reg2)
//  sens2_valid  out  1  bot 2 event pending
//  sens2_ready  in   1  scoreboard accepts bot 2 event
//  map_req      out  1  1-cycle pulse: both bots stable at ZONE_GOAL
//  ovf          out  2  sticky per-bot overflow {bot2,bot1}
// BEHAVIOUR
//  Reset (rst=0, async): all codes 3'b000, valids 0, map_req 0, ovf 0, sync flops 0,
//   debounce counters 0; stable code = 3'b000, so no event fires for 000 after reset.
//  Per channel, identical and independent:
//  - 2-flop synchroniser; raw-to-debouncer latency 2 cycles.
//  - Debounce: synced != candidate -> candidate <= synced, cnt <= 0; else cnt
//    increments, saturating at DEBOUNCE_CYCLES. On the cycle cnt reaches
//    DEBOUNCE_CYCLES-1 with candidate != stable: stable <= candidate, one accept strobe.
//    Worst-case raw-change -> valid latency = 2 + DEBOUNCE_CYCLES + 1 cycles.
//  - Output holding register, states EMPTY / FULL:
//    EMPTY + strobe -> FULL, code <= stable, valid=1 next cycle.
//    FULL + ready -> EMPTY (no strobe), valid drops next cycle.
//    FULL + ready + strobe same cycle -> stays FULL, code <= new stable (no bubble).
//    FULL + !ready + strobe -> code overwritten with newest, ovf[bot] <= 1 (sticky).
//  - valid, once high, stays high until ready; code changes only on overwrite or load.
//  map_req: pulses 1 cycle on the first cycle both stable codes == 3'b111; re-arms
//   only after either stable code leaves 3'b111. Independent of handshakes.
//  Glitch shorter than DEBOUNCE_CYCLES: no event, counter restarts.
//  ovf clears only on reset.
// CONFIGURATION
//  SENSOR_GLITCH_CNT_EN defined: adds outputs glitch1_cnt/glitch2_cnt [7:0]; each
//   increments (saturating at 255) when candidate changes before reaching
//   DEBOUNCE_CYCLES while candidate != stable; reset to 0.
//  Not defined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  Package sensor_evt_pkg: ZONE_IDLE=3'b000, ZONE_GOAL=3'b111, zone code typedef
//   (3-bit), hold-state enum {EMPTY,FULL}.
//  Sub-module sensor_debounce (sync + debounce + accept strobe + optional glitch
//   counter), instantiated twice; top holds the two holding regs, map_req, ovf.
// TESTING
//  1 rst low mid-event with valid=1 -> valid/code/ovf = 0 immediately, no clk needed.
//  2 sens1_raw 000->011 held 20 cycles, ready=1 -> one valid pulse, code 3'b011,
//    valid within 13 cycles of change; bot 2 outputs unchanged.
//  3 sens2_raw 000->101 for 5 cycles then back -> no valid (DEBOUNCE_CYCLES=10);
//    with SENSOR_GLITCH_CNT_EN, glitch2_cnt == 1.
//  4 ready=0, sens1_raw 001 then 010 (each held 15) -> code 3'b010, valid=1, ovf=2'b01;
//    assert ready 1 cycle -> valid drops, ovf stays 2'b01.
//  5 both raw -> 111 same cycle, held 30 -> map_req exactly one 1-cycle pulse;
//    bot1 -> 110 then 111 again -> second pulse.
//  6 sweep 000..111 every 10 cycles x10 loops, ready=1 -> one event per change, ovf=0.

Source files
------------

// File: rtl/sensor_evt_pkg.sv
// Shared zone codes and types for the sensor event front end.
package sensor_evt_pkg;

    localparam logic [2:0] ZONE_IDLE = 3'b000;
    localparam logic [2:0] ZONE_GOAL = 3'b111;

    typedef logic [2:0] zone_t;

    // Output holding register occupancy.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } hold_state_t;

endpackage

// File: rtl/sensor_debounce.sv
// Per-bot sensor conditioning: 2-flop synchroniser, debounce counter and a
// one-cycle accept strobe each time a new stable zone code is taken.
// Optional build macro SENSOR_GLITCH_CNT_EN adds a saturating count of
// candidate changes that were abandoned before being accepted.
module sensor_debounce
    import sensor_evt_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 10,
    parameter int CNT_W           = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] raw,
    output logic [2:0] stable,
    output logic       accept
`ifdef SENSOR_GLITCH_CNT_EN
    ,
    output logic [7:0] glitch_cnt
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
    // The accept fires on the cycle the counter moves onto DEBOUNCE_CYCLES-1.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);

    zone_t            sync1;
    zone_t            sync2;
    zone_t            cand;
    zone_t            stable_q;
    logic [CNT_W-1:0] cnt;
    logic             accept_q;
    logic             changed;
    logic             hit;

    assign changed = (sync2 != cand);
    assign hit     = !changed && (cnt == CNT_LAST) && (cand != stable_q);

    // Two-stage synchroniser for the asynchronous raw sensor bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= ZONE_IDLE;
            sync2 <= ZONE_IDLE;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Track the candidate code and how long it has held, saturating.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cand <= ZONE_IDLE;
            cnt  <= '0;
        end else if (changed) begin
            cand <= sync2;
            cnt  <= '0;
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Promote the candidate to stable once and strobe the holding register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stable_q <= ZONE_IDLE;
            accept_q <= 1'b0;
        end else begin
            accept_q <= hit;
            if (hit) begin
                stable_q <= cand;
            end
        end
    end

`ifdef SENSOR_GLITCH_CNT_EN
    // Count candidates dropped before acceptance while a change was pending.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            glitch_cnt <= 8'd0;
        end else if (changed && (cand != stable_q) && (cnt < CNT_MAX)
                     && (glitch_cnt != 8'hFF)) begin
            glitch_cnt <= glitch_cnt + 8'd1;
        end
    end
`endif

    assign stable = stable_q;
    assign accept = accept_q;

endmodule

// File: rtl/sensor_event_tx.sv
// Two-bot sensor event transmitter: debounced zone codes are offered on a
// valid/ready channel per bot through a one-deep overwrite-on-full holding
// register, with sticky overflow flags and a map_req pulse when both bots
// settle on the goal zone.
// Optional build macro SENSOR_GLITCH_CNT_EN exposes glitch1_cnt/glitch2_cnt.
//
// Holding register states:
//   state | meaning
//   EMPTY | no event pending, valid low
//   FULL  | event pending, valid high until ready
module sensor_event_tx
    import sensor_evt_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 10,
    parameter int CNT_W           = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] sens1_raw,
    input  logic [2:0] sens2_raw,
    output logic [2:0] sens1_code,
    output logic       sens1_valid,
    input  logic       sens1_ready,
    output logic [2:0] sens2_code,
    output logic       sens2_valid,
    input  logic       sens2_ready,
    output logic       map_req,
    output logic [1:0] ovf
`ifdef SENSOR_GLITCH_CNT_EN
    ,
    output logic [7:0] glitch1_cnt,
    output logic [7:0] glitch2_cnt
`endif
);

    zone_t      raw_v    [2];
    zone_t      stable_v [2];
    zone_t      code_v   [2];
    logic [1:0] ready_v;
    logic [1:0] valid_v;
    logic       both_goal;
    logic       goal_q;
    logic       map_q;
`ifdef SENSOR_GLITCH_CNT_EN
    logic [7:0] glitch_v [2];
`endif

    assign raw_v[0] = sens1_raw;
    assign raw_v[1] = sens2_raw;
    assign ready_v  = {sens2_ready, sens1_ready};

    for (genvar b = 0; b < 2; b++) begin : g_bot
        zone_t       stable_b;
        logic        accept_b;
        hold_state_t state_q;
        hold_state_t state_nxt;
        logic        load;
        logic        set_ovf;
        zone_t       code_q;
        logic        ovf_q;

        sensor_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_debounce (
            .clk       (clk),
            .rst       (rst),
            .raw       (raw_v[b]),
            .stable    (stable_b),
            .accept    (accept_b)
`ifdef SENSOR_GLITCH_CNT_EN
            ,
            .glitch_cnt(glitch_v[b])
`endif
        );

        // Holding register state.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state_q <= EMPTY;
            end else begin
                state_q <= state_nxt;
            end
        end

        // Next state, load and overflow decisions; a strobe always wins so
        // a simultaneous ready+strobe hands over without a bubble.
        always_comb begin
            state_nxt = state_q;
            load      = 1'b0;
            set_ovf   = 1'b0;
            case (state_q)
                EMPTY: begin
                    if (accept_b) begin
                        state_nxt = FULL;
                        load      = 1'b1;
                    end
                end
                FULL: begin
                    if (accept_b) begin
                        load    = 1'b1;
                        set_ovf = !ready_v[b];
                    end else if (ready_v[b]) begin
                        state_nxt = EMPTY;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end

        // Code register and sticky overflow flag.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                code_q <= ZONE_IDLE;
                ovf_q  <= 1'b0;
            end else begin
                if (load) begin
                    code_q <= stable_b;
                end
                if (set_ovf) begin
                    ovf_q <= 1'b1;
                end
            end
        end

        assign stable_v[b] = stable_b;
        assign code_v[b]   = code_q;
        assign valid_v[b]  = (state_q == FULL);
        assign ovf[b]      = ovf_q;
    end

    assign both_goal = (stable_v[0] == ZONE_GOAL) && (stable_v[1] == ZONE_GOAL);

    // Rising-edge detect on "both at goal"; re-arms once either leaves.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            goal_q <= 1'b0;
            map_q  <= 1'b0;
        end else begin
            goal_q <= both_goal;
            map_q  <= both_goal && !goal_q;
        end
    end

    assign sens1_code  = code_v[0];
    assign sens1_valid = valid_v[0];
    assign sens2_code  = code_v[1];
    assign sens2_valid = valid_v[1];
    assign map_req     = map_q;

`ifdef SENSOR_GLITCH_CNT_EN
    assign glitch1_cnt = glitch_v[0];
    assign glitch2_cnt = glitch_v[1];
`endif

endmodule

// File: tb/tb_sensor_event_tx.sv
// Bench for sensor_event_tx: directed scenarios with literal expectations plus
// randomized traffic, all outputs compared every cycle against a model built
// from run lengths of the raw sensor samples.
module tb_sensor_event_tx;

    localparam int D = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] raw1 = 3'b000;
    logic [2:0] raw2 = 3'b000;
    logic       rdy1 = 1'b0;
    logic       rdy2 = 1'b0;
    logic [2:0] code1;
    logic [2:0] code2;
    logic       valid1;
    logic       valid2;
    logic       map_req;
    logic [1:0] ovf;
`ifdef SENSOR_GLITCH_CNT_EN
    logic [7:0] g1;
    logic [7:0] g2;
`endif

    sensor_event_tx #(.DEBOUNCE_CYCLES(D), .CNT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .sens1_raw  (raw1),
        .sens2_raw  (raw2),
        .sens1_code (code1),
        .sens1_valid(valid1),
        .sens1_ready(rdy1),
        .sens2_code (code2),
        .sens2_valid(valid2),
        .sens2_ready(rdy2),
        .map_req    (map_req),
        .ovf        (ovf)
`ifdef SENSOR_GLITCH_CNT_EN
        ,
        .glitch1_cnt(g1),
        .glitch2_cnt(g2)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Model: a raw value is taken once it has been sampled D edges in a row;
    // it becomes stable two edges later (synchroniser), and the channel sees
    // it one edge after that.
    int       run      [2];
    logic [2:0] prev_m [2];
    logic [2:0] st_m   [2];
    logic [2:0] code_m [2];
    bit       full_m   [2];
    bit       ovf_m    [2];
    bit       strobe_m [2];
    bit       p1_v     [2];
    bit       p2_v     [2];
    logic [2:0] p1_d   [2];
    logic [2:0] p2_d   [2];
    bit       map_m;
    bit       bg_old;
    logic [2:0] rin    [2];
    bit       rdy_in   [2];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int b = 0; b < 2; b++) begin
                run[b] = D + 1; prev_m[b] = 3'b000; st_m[b] = 3'b000;
                code_m[b] = 3'b000; full_m[b] = 0; ovf_m[b] = 0;
                strobe_m[b] = 0; p1_v[b] = 0; p2_v[b] = 0;
                p1_d[b] = 3'b000; p2_d[b] = 3'b000;
            end
            map_m = 0; bg_old = 0;
        end else begin
            rin[0] = raw1; rin[1] = raw2;
            rdy_in[0] = rdy1; rdy_in[1] = rdy2;
            for (int b = 0; b < 2; b++) begin
                if (strobe_m[b]) begin
                    if (full_m[b] && !rdy_in[b]) ovf_m[b] = 1;
                    full_m[b] = 1;
                    code_m[b] = st_m[b];
                end else if (full_m[b] && rdy_in[b]) begin
                    full_m[b] = 0;
                end
            end
            map_m  = (st_m[0] == 3'b111) && (st_m[1] == 3'b111) && !bg_old;
            bg_old = (st_m[0] == 3'b111) && (st_m[1] == 3'b111);
            for (int b = 0; b < 2; b++) begin
                strobe_m[b] = 0;
                if (p2_v[b] && p2_d[b] != st_m[b]) begin
                    st_m[b] = p2_d[b];
                    strobe_m[b] = 1;
                end
                p2_v[b] = p1_v[b]; p2_d[b] = p1_d[b];
                if (rin[b] != prev_m[b]) run[b] = 1;
                else if (run[b] <= D) run[b] = run[b] + 1;
                prev_m[b] = rin[b];
                p1_v[b] = (run[b] == D);
                p1_d[b] = rin[b];
            end
        end
    end

    int ev1 = 0;
    int ev2 = 0;
    int mapc = 0;
    always @(posedge clk) begin
        if (rst) begin
            if (valid1 && rdy1) ev1++;
            if (valid2 && rdy2) ev2++;
            if (map_req) mapc++;
        end
    end

    // Advance n cycles, comparing every output against the model each cycle.
    task automatic tick(input int n);
        logic [11:0] act, exp;
        repeat (n) begin
            @(negedge clk);
            if (chk_en && rst) begin
                act = {code1, valid1, code2, valid2, map_req, ovf};
                exp = {code_m[0], full_m[0], code_m[1], full_m[1], map_m, ovf_m[1], ovf_m[0]};
                total++;
                if (act !== exp) begin
                    bad++;
                    $display("FAIL cycle_outputs t=%0t got={c1,v1,c2,v2,map,ovf}=%b want=%b",
                             $time, act, exp);
                end
            end
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    int e1, e2, m0, k, h1, h2;
    bit found;
    logic [2:0] cap;

    initial begin
        tick(3);
        rst = 1'b1;
        chk_en = 1'b1;
        tick(2);
        check("reset_code1", code1, 0);
        check("reset_valid1", valid1, 0);
        check("reset_ovf", ovf, 0);
        check("reset_map", map_req, 0);

        // Single clean event on bot 1.
        rdy1 = 1; rdy2 = 1;
        e1 = ev1; e2 = ev2;
        raw1 = 3'b011;
        found = 0; k = 0; cap = 3'b000;
        while (!found && k < 13) begin
            tick(1);
            k++;
            if (valid1) begin found = 1; cap = code1; end
        end
        check("t2_valid_within_13", found, 1);
        check("t2_code", cap, 3'b011);
        tick(20 - k);
        check("t2_one_event", ev1 - e1, 1);
        check("t2_bot2_events", ev2 - e2, 0);
        check("t2_bot2_code", code2, 0);

        // Short glitch on bot 2.
        e2 = ev2;
        raw2 = 3'b101;
        tick(5);
        raw2 = 3'b000;
        tick(20);
        check("t3_no_event", ev2 - e2, 0);
        check("t3_valid2", valid2, 0);
`ifdef SENSOR_GLITCH_CNT_EN
        check("t3_glitch2", g2, 1);
`endif

        // Overwrite while stalled.
        rdy1 = 0;
        raw1 = 3'b001;
        tick(15);
        raw1 = 3'b010;
        tick(15);
        check("t4_code", code1, 3'b010);
        check("t4_valid", valid1, 1);
        check("t4_ovf", ovf, 2'b01);
        rdy1 = 1;
        tick(1);
        rdy1 = 0;
        tick(1);
        check("t4_valid_dropped", valid1, 0);
        check("t4_ovf_sticky", ovf, 2'b01);

        // Asynchronous reset with an event pending.
        raw1 = 3'b011;
        tick(15);
        check("t1_pre_valid", valid1, 1);
        chk_en = 0;
        #1 rst = 0;
        #1;
        check("t1_valid", valid1, 0);
        check("t1_code", code1, 0);
        check("t1_ovf", ovf, 0);
        raw1 = 3'b000; raw2 = 3'b000;
        tick(3);
        rst = 1;
        chk_en = 1;
        rdy1 = 1; rdy2 = 1;
        tick(3);

        // Both bots at goal.
        m0 = mapc;
        raw1 = 3'b111; raw2 = 3'b111;
        tick(30);
        check("t5_first_pulse", mapc - m0, 1);
        raw1 = 3'b110;
        tick(15);
        raw1 = 3'b111;
        tick(15);
        check("t5_second_pulse", mapc - m0, 2);

        // Sweep of every code, 10 cycles each.
        e1 = ev1; e2 = ev2;
        for (int l = 0; l < 10; l++) begin
            for (int v = 0; v < 8; v++) begin
                raw1 = 3'(v);
                raw2 = 3'(7 - v);
                tick(10);
            end
        end
        tick(20);
        check("t6_events1", ev1 - e1, 80);
        check("t6_events2", ev2 - e2, 79);
        check("t6_ovf", ovf, 0);

        // Randomized traffic, checked against the model every cycle.
        h1 = 0; h2 = 0;
        for (int c = 0; c < 4000; c++) begin
            if (h1 == 0) begin raw1 = 3'($urandom_range(0, 7)); h1 = $urandom_range(1, 25); end
            if (h2 == 0) begin raw2 = 3'($urandom_range(0, 7)); h2 = $urandom_range(1, 25); end
            h1--; h2--;
            rdy1 = ($urandom_range(0, 3) != 0);
            rdy2 = ($urandom_range(0, 2) == 0);
            tick(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
